// File: rtl/mux2_1.sv
`default_nettype none
// ============================================================================
//  Module   : mux2_1
//  Brief    : 2:1 data multiplexer with a combinational output, an
//             enable-gated registered copy of the result and of the select,
//             and a saturating counter of registered select transitions.
//  Revision : 1.0 - initial release
// ============================================================================
module mux2_1 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             s,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             sel_q,
    output logic [15:0]      sel_changes
);

    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    logic [WIDTH-1:0] w_out;
    logic [WIDTH-1:0] r_out_q;
    logic             r_sel_q;
    logic [15:0]      r_sel_changes;
    logic             w_sel_toggle;

    // Combinational select. An unknown select propagates X in simulation;
    // the X arm is unreachable for a two-state select, so synthesis reduces
    // this to "s == 1 picks d1, anything else picks d0".
    always_comb begin
        if (s == 1'b1) begin
            w_out = d1;
        end else if (s == 1'b0) begin
            w_out = d0;
        end else begin
            w_out = {WIDTH{1'bx}};
        end
    end

    // A counted transition is an enabled capture of a select that differs
    // from the one currently held.
    assign w_sel_toggle = (s != r_sel_q);

    // Output and select registers: reset wins over enable, enable=0 holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_q <= '0;
            r_sel_q <= 1'b0;
        end else if (en) begin
            r_out_q <= w_out;
            r_sel_q <= s;
        end
    end

    // Saturating select-transition counter; sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel_changes <= '0;
        end else if (en && w_sel_toggle && (r_sel_changes != c_CNT_MAX)) begin
            r_sel_changes <= r_sel_changes + 16'd1;
        end
    end

    assign out         = w_out;
    assign out_q       = r_out_q;
    assign sel_q       = r_sel_q;
    assign sel_changes = r_sel_changes;

endmodule
`default_nettype wire

// File: tb/tb_mux2_1.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux2_1
//  Brief    : Self-checking bench for mux2_1. Stimulus pushes hand-computed
//             expected register values into a scoreboard queue; a monitor
//             pops one entry after each clock edge and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux2_1;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst;
    logic             en;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic             s;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_q;
    logic             sel_q;
    logic [15:0]      sel_changes;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] q;
        logic             sel;
        logic [15:0]      cnt;
    } exp_t;

    exp_t sb[$];
    int   n_cmp;
    int   n_bad;

    mux2_1 #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .d0          (d0),
        .d1          (d1),
        .s           (s),
        .out         (out),
        .out_q       (out_q),
        .sel_q       (sel_q),
        .sel_changes (sel_changes)
    );

    // 10 ns clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive a full input vector on the falling edge, ahead of the next rise.
    task automatic drive(input logic r, input logic e, input logic sv,
                         input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] a1);
        @(negedge clk);
        rst = r;
        en  = e;
        s   = sv;
        d0  = a0;
        d1  = a1;
    endtask

    // Queue the register state expected after the coming rising edge.
    task automatic expect_edge(input string nm, input logic [WIDTH-1:0] q,
                               input logic sel, input logic [15:0] cnt);
        exp_t e;
        e.name = nm;
        e.q    = q;
        e.sel  = sel;
        e.cnt  = cnt;
        sb.push_back(e);
    endtask

    // Immediate check of the combinational output.
    task automatic check_out(input string nm, input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (out !== exp) begin
            n_bad++;
            $display("FAIL %s: out=%h expected %h", nm, out, exp);
        end
    endtask

    // Monitor: one scoreboard entry per edge that has one queued.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (out_q !== e.q) begin
                n_bad++;
                $display("FAIL %s.out_q: got %h expected %h", e.name, out_q, e.q);
            end
            n_cmp++;
            if (sel_q !== e.sel) begin
                n_bad++;
                $display("FAIL %s.sel_q: got %b expected %b", e.name, sel_q, e.sel);
            end
            n_cmp++;
            if (sel_changes !== e.cnt) begin
                n_bad++;
                $display("FAIL %s.sel_changes: got %h expected %h", e.name, sel_changes, e.cnt);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus.
    initial begin
        logic [15:0] exp_cnt;
        logic        sv;
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1; en = 1'b0; s = 1'b0; d0 = '0; d1 = '0;

        // Reset with en=0: reset wins and clears everything.
        drive(1'b1, 1'b0, 1'b0, 16'd1, 16'd15);
        expect_edge("reset_en0", 16'h0000, 1'b0, 16'h0000);

        // Combinational path, no clock edge between the checks.
        #1 check_out("comb_s0", 16'd1);
        s = 1'b1;
        #1 check_out("comb_s1", 16'd15);
        s = 1'b0;

        // Reset with en=1, then first enabled edge loads s=1.
        drive(1'b1, 1'b1, 1'b0, 16'd0, 16'hABCD);
        expect_edge("reset_en1", 16'h0000, 1'b0, 16'h0000);
        drive(1'b0, 1'b1, 1'b1, 16'd0, 16'hABCD);
        expect_edge("first_load", 16'hABCD, 1'b1, 16'h0001);

        // Load 0001 via s=0 (second transition), then hold with en=0.
        drive(1'b0, 1'b1, 1'b0, 16'h0001, 16'hFFFF);
        expect_edge("load_0001", 16'h0001, 1'b0, 16'h0002);
        drive(1'b0, 1'b0, 1'b1, 16'h1234, 16'h5678);
        expect_edge("hold1", 16'h0001, 1'b0, 16'h0002);
        #1 check_out("hold1_comb", 16'h5678);
        drive(1'b0, 1'b0, 1'b0, 16'h9999, 16'h1111);
        expect_edge("hold2", 16'h0001, 1'b0, 16'h0002);
        #1 check_out("hold2_comb", 16'h9999);
        drive(1'b0, 1'b0, 1'b1, 16'hAAAA, 16'hBBBB);
        expect_edge("hold3", 16'h0001, 1'b0, 16'h0002);
        #1 check_out("hold3_comb", 16'hBBBB);

        // Build up out_q=00FF with sel_changes=5, then reset mid-operation.
        drive(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0011);
        expect_edge("build3", 16'h0011, 1'b1, 16'h0003);
        drive(1'b0, 1'b1, 1'b0, 16'h0022, 16'h0000);
        expect_edge("build4", 16'h0022, 1'b0, 16'h0004);
        drive(1'b0, 1'b1, 1'b1, 16'h0000, 16'h00FF);
        expect_edge("build5", 16'h00FF, 1'b1, 16'h0005);
        drive(1'b1, 1'b1, 1'b1, 16'h1111, 16'h2222);
        expect_edge("mid_reset", 16'h0000, 1'b0, 16'h0000);
        #1 check_out("rst_comb_pre", 16'h2222);
        @(posedge clk);
        #2 check_out("rst_comb_post", 16'h2222);

        // Equal data inputs: select does not matter.
        drive(1'b0, 1'b1, 1'b0, 16'h5A5A, 16'h5A5A);
        expect_edge("eq_load0", 16'h5A5A, 1'b0, 16'h0000);
        #1 check_out("eq_s0", 16'h5A5A);
        s = 1'b1;
        #1 check_out("eq_s1", 16'h5A5A);
        s = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 16'h5A5A, 16'h5A5A);
        expect_edge("eq_load1", 16'h5A5A, 1'b1, 16'h0001);

        // Saturation: clear, then toggle s on 70000 enabled edges.
        drive(1'b1, 1'b0, 1'b0, 16'h1111, 16'h2222);
        expect_edge("sat_reset", 16'h0000, 1'b0, 16'h0000);
        exp_cnt = 16'h0000;
        for (int i = 0; i < 70000; i++) begin
            sv = (i % 2 == 0);
            drive(1'b0, 1'b1, sv, 16'h1111, 16'h2222);
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            if (i < 2 || (i >= 65530 && i < 65540) || i >= 69995)
                expect_edge("sat", sv ? 16'h2222 : 16'h1111, sv, exp_cnt);
        end

        // Saturated count holds across a disabled edge too.
        drive(1'b0, 1'b0, 1'b1, 16'h3333, 16'h4444);
        expect_edge("sat_hold", 16'h1111, 1'b0, 16'hFFFF);

        // Let the monitor drain the scoreboard.
        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux2_1.md
MUX2_1 -- requirements
Module: mux2_1

Interface
REQ-001 Parameter: WIDTH, default 16, data width of inputs and outputs in bits (legal range 1..64).
REQ-002 Port: clk  input  1  single clock; all sequential elements update on the rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: en  input  1  register-stage enable; 1 = capture, 0 = hold.
REQ-005 Port: d0  input  WIDTH  data input, selected when s = 0.
REQ-006 Port: d1  input  WIDTH  data input, selected when s = 1.
REQ-007 Port: s  input  1  select.
REQ-008 Port: out  output  WIDTH  combinational mux result.
REQ-009 Port: out_q  output  WIDTH  registered mux result.
REQ-010 Port: sel_q  output  1  registered copy of s.
REQ-011 Port: sel_changes  output  16  saturating count of registered select transitions.

Function
REQ-012 out SHALL equal d0 when s = 0 and d1 when s = 1, with zero-cycle latency, independent of clk, rst and en.
REQ-013 If s is X or Z, out SHALL be X in simulation; synthesis SHALL treat any non-1 value as 0.
REQ-014 out SHALL settle to the new value within the same delta cycle in which any of d0, d1 or s changes.
REQ-015 On a rising clk edge with rst = 0 and en = 1, out_q SHALL load the current value of out.
REQ-016 On the same edge, sel_q SHALL load s.
REQ-017 On a rising clk edge with rst = 0 and en = 0, out_q and sel_q SHALL hold their values.
REQ-018 sel_changes SHALL increment by 1 on an enabled edge where the new value of s differs from the current sel_q.
REQ-019 sel_changes SHALL saturate at 16'hFFFF and never wrap.
REQ-020 out_q and sel_q SHALL lag the combinational path by exactly one enabled clock edge.
REQ-021 There SHALL be no path from out_q, sel_q or sel_changes back into out.
REQ-022 When d0 equals d1, out and out_q SHALL equal that value regardless of s.

Reset
REQ-023 On a rising clk edge with rst = 1, out_q SHALL be 0, sel_q SHALL be 0 and sel_changes SHALL be 0, regardless of en.
REQ-024 rst SHALL take priority over en.
REQ-025 rst SHALL NOT affect out; the combinational path remains live during reset.
REQ-026 An assertion of rst mid-operation SHALL discard held state on that edge.
REQ-027 The first enabled edge after reset deasserts SHALL load normally. If s = 1 on that edge, sel_changes SHALL become 1 (0 -> 1 transition against the reset value).

Verification
REQ-028 WIDTH=16, d0=1, d1=15, s=0 -> out=1 immediately; s=1 -> out=15 immediately, with no clock edge required.
REQ-029 rst=1 for one edge, then en=1, s=1, d1=16'hABCD, one edge -> out_q=16'hABCD, sel_q=1, sel_changes=1.
REQ-030 After loading out_q=16'h0001, set en=0 and change s, d0 and d1, then apply 3 edges -> out_q stays 16'h0001, sel_changes unchanged, while out tracks the inputs.
REQ-031 Toggle s on every enabled edge for 70000 edges -> sel_changes = 16'hFFFF and holds there.
REQ-032 With out_q=16'h00FF and sel_changes=5, assert rst=1 with en=1 for one edge -> out_q=0, sel_q=0, sel_changes=0, and out still equals the mux of the current inputs.
REQ-033 d0=d1=16'h5A5A with s toggling -> out=16'h5A5A throughout; out_q=16'h5A5A after one enabled edge.
